// File: rtl/uart_codeloader.sv
// Boot loader: receives a framed program image over UART, writes it into code RAM,
// answers ACK/NAK and releases the core once a valid image is loaded or the skip strap is set.
//
// state  | meaning
// INIT   | one cycle after reset, sample skip strap
// SYNC   | hunt for 0x55 sync byte
// LEN_LO | capture word count, low byte
// LEN_HI | capture word count, high byte, range check
// DATA   | assemble payload words and write them to RAM
// CSUM   | compare received checksum
// RESP   | wait for idle transmitter, send ACK/NAK
// DONE   | image loaded, core released
module uart_codeloader #(
  parameter int ADDR_W         = 12,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              skip_codeload,
  input  logic              rx_data_valid,
  input  logic [7:0]        rx_data,
  input  logic              rx_error,
  input  logic              transmitter_busy,
  output logic              tx_data_valid,
  output logic [7:0]        tx_data,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic              boot_done
);

  localparam int          TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;
  localparam logic [7:0]  SYNC_BYTE = 8'h55;
  localparam logic [7:0]  ACK_BYTE  = 8'h06;
  localparam logic [7:0]  NAK_BYTE  = 8'h15;

  typedef enum logic [2:0] {INIT, SYNC, LEN_LO, LEN_HI, DATA, CSUM, RESP, DONE} state_t;

  state_t        state, state_next;
  logic [15:0]   len;
  logic [15:0]   wcnt;
  logic [1:0]    idx;
  logic [23:0]   wasm;
  logic [7:0]    csum;
  logic [TW-1:0] tmr;
  logic          resp_ack;

  logic          rx_byte, active, timeout, abort, send;
  logic          len_bad, last_word, enter_resp, resp_ack_next;
  logic [15:0]   len_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= INIT;
    else        state <= state_next;
  end

  always_comb begin
    // an error strobe wins over a coincident byte
    rx_byte       = rx_data_valid && !rx_error;
    active        = state inside {LEN_LO, LEN_HI, DATA, CSUM};
    timeout       = active && (tmr == '0) && !rx_data_valid;
    abort         = active && (rx_error || timeout);
    len_full      = {rx_data, len[7:0]};
    len_bad       = (len_full == 16'd0) || ({1'b0, len_full} > MAX_WORDS);
    last_word     = (wcnt + 16'd1) == len;
    send          = (state == RESP) && !transmitter_busy;
    state_next    = state;
    enter_resp    = 1'b0;
    resp_ack_next = 1'b0;
    case (state)
      INIT:   state_next = skip_codeload ? DONE : SYNC;
      SYNC:   if (rx_byte && rx_data == SYNC_BYTE) state_next = LEN_LO;
      LEN_LO: if (rx_byte) state_next = LEN_HI;
      LEN_HI: if (rx_byte) begin
                if (len_bad) begin
                  state_next = RESP;
                  enter_resp = 1'b1;
                end else begin
                  state_next = DATA;
                end
              end
      DATA:   if (rx_byte && idx == 2'd3 && last_word) state_next = CSUM;
      CSUM:   if (rx_byte) begin
                state_next    = RESP;
                enter_resp    = 1'b1;
                resp_ack_next = (rx_data == csum);
              end
      RESP:   if (send) state_next = resp_ack ? DONE : SYNC;
      DONE:   state_next = DONE;
      default: state_next = INIT;
    endcase
    if (abort) begin
      state_next    = RESP;
      enter_resp    = 1'b1;
      resp_ack_next = 1'b0;
    end
  end

  assign tx_data_valid = send;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_data   <= 8'h00;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= 32'h0;
      boot_done <= 1'b0;
      len       <= 16'h0;
      wcnt      <= 16'h0;
      idx       <= 2'd0;
      wasm      <= 24'h0;
      csum      <= 8'h00;
      tmr       <= '0;
      resp_ack  <= 1'b0;
    end else begin
      ram_we <= 1'b0;
      if (enter_resp) begin
        resp_ack <= resp_ack_next;
        tx_data  <= resp_ack_next ? ACK_BYTE : NAK_BYTE;
      end
      if ((send && resp_ack) || state == DONE) boot_done <= 1'b1;
      // idle timer reloads outside the frame and on every received strobe
      if (rx_data_valid || !active) tmr <= TW'(TIMEOUT_CYCLES);
      else if (tmr != '0)           tmr <= tmr - 1'b1;
      if (rx_byte) begin
        case (state)
          LEN_LO: len[7:0] <= rx_data;
          LEN_HI: begin
            len[15:8] <= rx_data;
            wcnt      <= 16'h0;
            idx       <= 2'd0;
            csum      <= 8'h00;
          end
          DATA: begin
            csum <= csum + rx_data;
            idx  <= idx + 2'd1;
            case (idx)
              2'd0: wasm[7:0]   <= rx_data;
              2'd1: wasm[15:8]  <= rx_data;
              2'd2: wasm[23:16] <= rx_data;
              default: begin
                ram_we    <= 1'b1;
                ram_addr  <= wcnt[ADDR_W-1:0];
                ram_wdata <= {rx_data, wasm};
                wcnt      <= wcnt + 16'd1;
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/uart_codeloader.md
# uart_codeloader

Hardware boot loader for the RISC-V SoC. It receives a program image from the host over the existing UART receiver and writes the image word by word into code RAM. It answers the host with a one-byte ACK or NAK through the UART transmitter. It holds the core in reset until a valid image has been loaded, or releases it at once when the codeload-skip strap is set.

## Interface
Parameters:
- ADDR_W, 12, code RAM word-address width; maximum image size is 2**ADDR_W words.
- TIMEOUT_CYCLES, 1000000, idle clock cycles allowed between bytes of one frame.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- skip_codeload  in  1  strap input (gpio_din[3]). Sampled in the first cycle after reset release.
- rx_data_valid  in  1  one-cycle strobe from the UART receiver; a byte is present.
- rx_data  in  8  received byte.
- rx_error  in  1  one-cycle strobe from the UART receiver; framing error.
- transmitter_busy  in  1  UART transmitter is busy.
- tx_data_valid  out  1  one-cycle strobe; send tx_data.
- tx_data  out  8  response byte.
- ram_we  out  1  one-cycle code RAM write strobe.
- ram_addr  out  ADDR_W  word address.
- ram_wdata  out  32  write data.
- boot_done  out  1  sticky; releases the core from reset.

## Operation
Frame format, sent by the host:
- Byte 1: sync byte 0x55.
- Bytes 2-3: word count N, little-endian, 16 bits.
- Next 4N bytes: N words, each little-endian.
- Final byte: checksum, the 8-bit sum mod 256 of all 4N payload bytes.

State machine states: INIT, SYNC, LEN_LO, LEN_HI, DATA, CSUM, RESP, DONE.
- INIT (one cycle after reset): skip_codeload=1 -> DONE; otherwise -> SYNC.
- SYNC: a byte equal to 0x55 -> LEN_LO. Any other byte is discarded silently. rx_error is ignored.
- LEN_LO / LEN_HI: capture N.
  - At the end of LEN_HI, N==0 or N>2**ADDR_W -> RESP with NAK.
  - Otherwise clear the word address, byte index and checksum, then -> DATA.
- DATA:
  - Shift each byte into the word assembler at byte position index[1:0]; byte 0 goes to bits [7:0].
  - Add each byte to the checksum.
  - On the 4th byte: issue a RAM write, increment the address.
  - After word N is written -> CSUM.
- CSUM: received byte == checksum -> RESP with ACK (0x06); otherwise RESP with NAK (0x15).
- RESP: wait until transmitter_busy==0, then pulse tx_data_valid for one cycle.
  - ACK -> DONE.
  - NAK -> SYNC.
- DONE: terminal state. All rx inputs are ignored. Only rst_n leaves DONE.

Abort conditions, valid in LEN_LO, LEN_HI, DATA and CSUM:
- rx_error, or the timeout counter reaching TIMEOUT_CYCLES -> RESP with NAK.
- Words already written are not rolled back.
- A partially assembled word is dropped.

Timeout counter:
- Cleared on every rx_data_valid and on entry to LEN_LO.
- Counts only in LEN_LO, LEN_HI, DATA and CSUM.

Simultaneous rx_data_valid and rx_error: the error wins and the byte is dropped.

Bytes received while in RESP are dropped. They do not count toward the next frame.

## Timing
Reset values:
- tx_data_valid=0, tx_data=0x00
- ram_we=0, ram_addr=0, ram_wdata=0
- boot_done=0
- State = INIT

Latencies:
- ram_we, with its ram_addr and ram_wdata, is registered. It asserts in the cycle after the rx_data_valid that carries the 4th byte of a word.
- ram_addr is word 0 for the first write and advances by one per write. It never wraps, because N is bounded.
- tx_data_valid asserts no earlier than the cycle after the CSUM byte or abort event. It asserts in the first cycle in which transmitter_busy==0 after that.
- boot_done:
  - skip path: asserts 2 cycles after rst_n deasserts (INIT, then DONE).
  - ACK path: asserts in the cycle after the ACK tx_data_valid pulse.
  - Once set, boot_done stays 1 until reset.

Reset asserted mid-frame:
- All outputs return to their reset values asynchronously.
- A pending RAM write is not issued.
- The frame is lost. After reset release, skip_codeload is sampled again.

Throughput: one byte per cycle is accepted (back-to-back rx_data_valid). No backpressure toward the receiver.

## Test plan
- Skip: skip_codeload=1 at reset release -> boot_done=1 two cycles later. ram_we never asserts. No tx_data_valid.
- Good image: 0x55, 0x02, 0x00, bytes 13 00 00 00, B7 02 00 10, checksum 0xDC -> two writes: addr 0 = 0x00000013, addr 1 = 0x100002B7. Then tx_data=0x06, then boot_done=1.
- Bad checksum: same frame with checksum 0xDD -> both writes occur. tx_data=0x15. boot_done stays 0. A correct frame resent afterwards yields ACK and boot_done=1.
- Length limits: N=0x0000 -> NAK right after LEN_HI, no writes. With ADDR_W=12, N=0x1001 -> NAK. N=0x1000 with full data -> last write at addr 0xFFF, then ACK.
- Abort: rx_error after 6 payload bytes -> exactly one write (addr 0). NAK is held while transmitter_busy=1 and sent the first cycle it drops. The FSM returns to SYNC. Garbage bytes 0xAA, 0x00 are then ignored.
- Timeout and reset: a frame stalls after LEN_HI for TIMEOUT_CYCLES -> NAK. A separate run asserts rst_n=0 in the middle of DATA -> all outputs reset immediately and the core stays held (boot_done=0).
